// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Memory-access stage of the 16-bit MISC-V pipeline. Issues
//            data-memory accesses over a req/ack handshake, stalls upstream
//            while an access is outstanding, and registers MEM/WB outputs.
// Options  : define MEM_TIMEOUT_EN to abort requests that are not acked
//            within TIMEOUT_CYCLES request cycles (squash + OMemErr pulse).
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              IRegWrite,
  input  logic              IMemRead,
  input  logic              IMemWrite,
  input  logic              IRegStore,
  input  logic [DATA_W-1:0] IALUResult,
  input  logic [DATA_W-1:0] I3rdArg,
  input  logic [DATA_W-1:0] IRd,
  input  logic              DMemAck,
  input  logic [DATA_W-1:0] DMemRData,
  output logic              DMemReq,
  output logic              DMemWE,
  output logic [DATA_W-1:0] DMemAddr,
  output logic [DATA_W-1:0] DMemWData,
  output logic              Stall,
  output logic              ORegWrite,
  output logic              ORegStore,
  output logic [DATA_W-1:0] OWBData,
  output logic [DATA_W-1:0] ORd,
  output logic              OValid,
  output logic              OMemErr
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;

  // Timeout window must fit the 8-bit counter.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_stage: TIMEOUT_CYCLES must be in 1..255");
  end

  logic [0:0] r_state;
  logic [0:0] w_next_state;
  logic       w_access;
  logic       w_issue;
  logic       w_ack_done;
  logic       w_timeout;
  logic       w_stall;

  assign w_access = IMemRead | IMemWrite;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] r_tcnt;
  logic       r_memerr;

  // A REQ cycle without ack is the last allowed one when it would bring the
  // count of unacked cycles up to TIMEOUT_CYCLES.
  assign w_timeout = (r_state == S_REQ) && !DMemAck && (r_tcnt == c_TO_LAST);

  // Unacked request-cycle counter; cleared whenever a request is issued.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_tcnt   <= 8'd0;
      r_memerr <= 1'b0;
    end else begin
      if (w_issue)
        r_tcnt <= 8'd0;
      else if (r_state == S_REQ && !DMemAck)
        r_tcnt <= r_tcnt + 8'd1;
      r_memerr <= w_timeout;
    end
  end

  assign OMemErr = r_memerr;
`else
  assign w_timeout = 1'b0;
  assign OMemErr   = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic: issue moves to REQ, ack or timeout returns to IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_access) w_next_state = S_REQ;
      S_REQ:   if (DMemAck || w_timeout) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode: issue/complete strobes and the combinational stall.
  always_comb begin
    w_issue    = 1'b0;
    w_ack_done = 1'b0;
    w_stall    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_issue = w_access;
        w_stall = w_access;
      end
      S_REQ: begin
        w_ack_done = DMemAck;
        w_stall    = !DMemAck && !w_timeout;
      end
      default: ;
    endcase
  end

  assign Stall = w_stall;

  // Memory-request registers: latched at issue, held until completion.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      DMemReq   <= 1'b0;
      DMemWE    <= 1'b0;
      DMemAddr  <= '0;
      DMemWData <= '0;
    end else if (w_issue) begin
      DMemReq   <= 1'b1;
      DMemWE    <= IMemWrite;
      DMemAddr  <= IALUResult;
      DMemWData <= I3rdArg;
    end else if (w_ack_done || w_timeout) begin
      DMemReq   <= 1'b0;
    end
  end

  // MEM/WB register: pass-through, access completion, timeout squash or bubble.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      OValid    <= 1'b0;
      ORegWrite <= 1'b0;
      ORegStore <= 1'b0;
      OWBData   <= '0;
      ORd       <= '0;
    end else if (r_state == S_IDLE && !w_access) begin
      OValid    <= 1'b1;
      ORegWrite <= IRegWrite;
      ORegStore <= IRegStore;
      ORd       <= IRd;
      OWBData   <= IALUResult;
    end else if (w_ack_done) begin
      OValid    <= 1'b1;
      ORegWrite <= IRegWrite;
      ORegStore <= IRegStore;
      ORd       <= IRd;
      OWBData   <= DMemWE ? IALUResult : DMemRData;
    end else if (w_timeout) begin
      OValid    <= 1'b1;
      ORegWrite <= 1'b0;
      ORegStore <= IRegStore;
      ORd       <= IRd;
    end else begin
      OValid    <= 1'b0;
      ORegWrite <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Directed self-checking bench for mem_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        IRegWrite, IMemRead, IMemWrite, IRegStore;
  logic [15:0] IALUResult, I3rdArg, IRd;
  logic        DMemAck;
  logic [15:0] DMemRData;
  logic        DMemReq, DMemWE;
  logic [15:0] DMemAddr, DMemWData;
  logic        Stall, ORegWrite, ORegStore, OValid, OMemErr;
  logic [15:0] OWBData, ORd;

  int n_pass  = 0;
  int n_total = 0;

  mem_stage #(.DATA_W(16), .TIMEOUT_CYCLES(4)) dut (
    .CLK(CLK), .Reset(Reset),
    .IRegWrite(IRegWrite), .IMemRead(IMemRead), .IMemWrite(IMemWrite),
    .IRegStore(IRegStore), .IALUResult(IALUResult), .I3rdArg(I3rdArg),
    .IRd(IRd), .DMemAck(DMemAck), .DMemRData(DMemRData),
    .DMemReq(DMemReq), .DMemWE(DMemWE), .DMemAddr(DMemAddr),
    .DMemWData(DMemWData), .Stall(Stall), .ORegWrite(ORegWrite),
    .ORegStore(ORegStore), .OWBData(OWBData), .ORd(ORd),
    .OValid(OValid), .OMemErr(OMemErr)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_nop();
    IRegWrite = 0; IMemRead = 0; IMemWrite = 0; IRegStore = 0;
    IALUResult = 16'h0; I3rdArg = 16'h0; IRd = 16'h0;
    DMemAck = 0; DMemRData = 16'h0;
  endtask

  task automatic test_reset();
    set_nop();
    Reset = 1;
    tick(); tick();
    Reset = 0;
    #1;
    n_total++;
    if ({DMemReq, DMemWE, ORegWrite, ORegStore, OValid, OMemErr} !== 6'b0) begin
      $display("FAIL reset_ctrl: got %b expected 000000",
               {DMemReq, DMemWE, ORegWrite, ORegStore, OValid, OMemErr});
    end else n_pass++;
    n_total++;
    if ({DMemAddr, DMemWData, OWBData, ORd} !== 64'h0) begin
      $display("FAIL reset_data: got %h expected 0", {DMemAddr, DMemWData, OWBData, ORd});
    end else n_pass++;
    n_total++;
    if (Stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", Stall);
    else n_pass++;
  endtask

  task automatic test_alu();
    IRegWrite = 1; IALUResult = 16'h1234; IRd = 16'd5; IRegStore = 1;
    #1;
    n_total++;
    if (Stall !== 1'b0) $display("FAIL alu_stall: got %b expected 0", Stall);
    else n_pass++;
    tick();
    n_total++;
    if ({OValid, ORegWrite, ORegStore, OWBData, ORd} !== {3'b111, 16'h1234, 16'd5}) begin
      $display("FAIL alu_wb: got v=%b w=%b s=%b d=%h rd=%h expected 1 1 1 1234 0005",
               OValid, ORegWrite, ORegStore, OWBData, ORd);
    end else n_pass++;
    set_nop();
  endtask

  task automatic test_load();
    int stalls = 0;
    IMemRead = 1; IALUResult = 16'h0040; IRd = 16'd7; IRegWrite = 1;
    #1;
    if (Stall) stalls++;
    tick();
    n_total++;
    if ({DMemReq, DMemWE, DMemAddr, OValid} !== {2'b10, 16'h0040, 1'b0}) begin
      $display("FAIL load_issue: got req=%b we=%b addr=%h v=%b expected 1 0 0040 0",
               DMemReq, DMemWE, DMemAddr, OValid);
    end else n_pass++;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (Stall) stalls++;
      tick();
    end
    n_total++;
    if ({DMemReq, DMemAddr, OValid} !== {1'b1, 16'h0040, 1'b0}) begin
      $display("FAIL load_wait: got req=%b addr=%h v=%b expected 1 0040 0",
               DMemReq, DMemAddr, OValid);
    end else n_pass++;
    DMemAck = 1; DMemRData = 16'hBEEF;
    #1;
    if (Stall) stalls++;
    n_total++;
    if (stalls !== 4) $display("FAIL load_stall_cycles: got %0d expected 4", stalls);
    else n_pass++;
    tick();
    set_nop();
    IMemRead = 1; IALUResult = 16'h0099;
    n_total++;
    if ({DMemReq, OValid, ORegWrite, OWBData, ORd} !== {3'b011, 16'hBEEF, 16'd7}) begin
      $display("FAIL load_wb: got req=%b v=%b w=%b d=%h rd=%h expected 0 1 1 beef 0007",
               DMemReq, OValid, ORegWrite, OWBData, ORd);
    end else n_pass++;
    // A following access bubbles the output: the load completed exactly once.
    tick();
    n_total++;
    if (OValid !== 1'b0 || DMemReq !== 1'b1)
      $display("FAIL load_once: got v=%b req=%b expected 0 1", OValid, DMemReq);
    else n_pass++;
    Reset = 1; set_nop(); tick(); Reset = 0;
  endtask

  task automatic test_store();
    IMemWrite = 1; IALUResult = 16'h0010; I3rdArg = 16'hA5A5; IRd = 16'd2;
    #1;
    n_total++;
    if (Stall !== 1'b1) $display("FAIL store_issue_stall: got %b expected 1", Stall);
    else n_pass++;
    tick();
    n_total++;
    if ({DMemReq, DMemWE, DMemAddr, DMemWData} !== {2'b11, 16'h0010, 16'hA5A5}) begin
      $display("FAIL store_req: got req=%b we=%b addr=%h wd=%h expected 1 1 0010 a5a5",
               DMemReq, DMemWE, DMemAddr, DMemWData);
    end else n_pass++;
    DMemAck = 1; DMemRData = 16'hFFFF;
    #1;
    n_total++;
    if (Stall !== 1'b0) $display("FAIL store_ack_stall: got %b expected 0", Stall);
    else n_pass++;
    tick();
    set_nop();
    n_total++;
    if ({DMemReq, OValid, ORegWrite, OWBData, ORd} !== {3'b010, 16'h0010, 16'd2}) begin
      $display("FAIL store_wb: got req=%b v=%b w=%b d=%h rd=%h expected 0 1 0 0010 0002",
               DMemReq, OValid, ORegWrite, OWBData, ORd);
    end else n_pass++;
  endtask

  task automatic test_both();
    IMemRead = 1; IMemWrite = 1; IALUResult = 16'h0022; I3rdArg = 16'h3333;
    IRd = 16'd3; IRegWrite = 1;
    tick();
    n_total++;
    if (DMemWE !== 1'b1 || DMemWData !== 16'h3333)
      $display("FAIL both_we: got we=%b wd=%h expected 1 3333", DMemWE, DMemWData);
    else n_pass++;
    DMemAck = 1; DMemRData = 16'hDEAD;
    tick();
    set_nop();
    n_total++;
    if (OValid !== 1'b1 || OWBData !== 16'h0022)
      $display("FAIL both_wb: got v=%b d=%h expected 1 0022", OValid, OWBData);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    IMemRead = 1; IALUResult = 16'h0050; IRd = 16'd9; IRegWrite = 1;
    tick(); tick();
    Reset = 1;
    tick();
    Reset = 0;
    n_total++;
    if ({DMemReq, DMemAddr, OValid, OWBData, ORd} !== 49'h0)
      $display("FAIL rst_mid_clear: got req=%b addr=%h v=%b d=%h rd=%h expected all 0",
               DMemReq, DMemAddr, OValid, OWBData, ORd);
    else n_pass++;
    // Late ack arrives while back in IDLE with an access presented.
    DMemAck = 1; DMemRData = 16'hFFFF;
    #1;
    n_total++;
    if (Stall !== 1'b1) $display("FAIL rst_mid_idle_stall: got %b expected 1", Stall);
    else n_pass++;
    tick();
    n_total++;
    if (OValid !== 1'b0 || OWBData !== 16'h0 || DMemReq !== 1'b1)
      $display("FAIL rst_mid_late_ack: got v=%b d=%h req=%b expected 0 0000 1",
               OValid, OWBData, DMemReq);
    else n_pass++;
    Reset = 1; set_nop(); tick(); Reset = 0;
  endtask

  task automatic test_no_err();
    n_total++;
    if (OMemErr !== 1'b0) $display("FAIL memerr_idle: got %b expected 0", OMemErr);
    else n_pass++;
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int stalls = 0;
    IMemRead = 1; IALUResult = 16'h0070; IRd = 16'd4; IRegWrite = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      if (Stall) stalls++;
      tick();
    end
    #1;
    n_total++;
    if (stalls !== 3 || Stall !== 1'b0)
      $display("FAIL to_stall: got stalls=%0d stall=%b expected 3 0", stalls, Stall);
    else n_pass++;
    tick();
    set_nop();
    n_total++;
    if ({OMemErr, OValid, ORegWrite, DMemReq} !== 4'b1100)
      $display("FAIL to_abort: got err=%b v=%b w=%b req=%b expected 1 1 0 0",
               OMemErr, OValid, ORegWrite, DMemReq);
    else n_pass++;
    tick();
    n_total++;
    if (OMemErr !== 1'b0) $display("FAIL to_pulse: got %b expected 0", OMemErr);
    else n_pass++;
  endtask
`endif

  initial begin
    Reset = 1;
    set_nop();
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_both();
    test_reset_mid();
    test_no_err();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 16-bit MISC-V pipeline.
- Consumes the registered EX/MEM outputs and performs the data-memory access through a req/ack handshake.
- Stalls the upstream pipeline while an access is outstanding.
- Drives registered MEM/WB outputs to the writeback stage. Non-memory instructions pass through in one cycle.

Parameters:
- DATA_W, 16, data/address width.
- TIMEOUT_CYCLES, 255, request cycles without ack before abort (used only with MEM_TIMEOUT_EN; must be 1..255).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- IRegWrite  in  1  writeback enable from EX/MEM.
- IMemRead  in  1  load request.
- IMemWrite  in  1  store request.
- IRegStore  in  1  control bit carried through to WB.
- IALUResult  in  16  address for loads/stores; result for ALU ops.
- I3rdArg  in  16  store data.
- IRd  in  16  destination register field.
- DMemAck  in  1  memory completion; sampled only in REQ.
- DMemRData  in  16  load data; valid with DMemAck.
- DMemReq  out  1  access request (registered).
- DMemWE  out  1  1=store, 0=load (registered).
- DMemAddr  out  16  latched address.
- DMemWData  out  16  latched store data.
- Stall  out  1  combinational; upstream registers hold while 1 (EX/MEM enable = ~Stall).
- ORegWrite  out  1  MEM/WB writeback enable.
- ORegStore  out  1  MEM/WB passthrough.
- OWBData  out  16  MEM/WB writeback data.
- ORd  out  16  MEM/WB destination.
- OValid  out  1  MEM/WB holds a completed instruction this cycle.
- OMemErr  out  1  one-cycle timeout pulse (0 when feature is off).

Behaviour:
- Reset: state=IDLE. DMemReq, DMemWE, DMemAddr, DMemWData, ORegWrite, ORegStore, OWBData, ORd, OValid and OMemErr are all 0. The timeout counter is 0. Reset overrides everything, including mid-access: the request drops on the next edge and any pending ack is discarded.
- Access = IMemRead | IMemWrite. If both are set, the access is a store (DMemWE=1) and the read is ignored.
- States: IDLE and REQ.
- IDLE, no access:
  - Stall=0.
  - Next edge: OValid=1, ORegWrite=IRegWrite, ORegStore=IRegStore, ORd=IRd, OWBData=IALUResult.
- IDLE, access:
  - Stall=1.
  - Next edge: DMemReq=1, DMemWE=IMemWrite, DMemAddr=IALUResult, DMemWData=I3rdArg; go to REQ.
  - MEM/WB bubble that edge: OValid=0, ORegWrite=0; ORd, OWBData and ORegStore hold.
- REQ, DMemAck=0:
  - Stall=1; MEM/WB bubble.
  - DMemReq and the address/data outputs are held stable.
- REQ, DMemAck=1:
  - Stall=0, so EX/MEM advances on this edge.
  - Next edge: DMemReq=0; OValid=1; ORegWrite=IRegWrite; ORegStore=IRegStore; ORd=IRd; go to IDLE.
  - OWBData = DMemRData for a load; IALUResult for a store.
- Back-to-back accesses: a new access seen in IDLE always costs one issue cycle. Minimum stage occupancy is 2 cycles for a memory instruction and 1 cycle for a non-memory instruction.
- DMemAck in IDLE is ignored.
- DMemRData is sampled only on the acked edge.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to REQ and increments each REQ cycle without ack.
  - When the count reaches TIMEOUT_CYCLES with no ack, that cycle acts as completion: Stall=0.
  - Next edge: DMemReq=0, OValid=1, ORegWrite=0 (the instruction is squashed), OMemErr=1 for one cycle, go to IDLE.
  - Ack and timeout in the same cycle: the ack wins and OMemErr stays 0.
- Undefined: REQ waits indefinitely; OMemErr is tied to 0; no counter logic exists.

Test Plan:
- Reset, then ALU op with IALUResult=0x1234, IRd=5, IRegWrite=1 -> Stall=0; next edge OValid=1, OWBData=0x1234, ORd=5, ORegWrite=1.
- Load, addr 0x0040; ack 3 cycles after DMemReq rises with DMemRData=0xBEEF -> Stall high for 4 cycles; DMemAddr=0x0040, DMemWE=0; then OWBData=0xBEEF, OValid=1 exactly once.
- Store, addr 0x0010, I3rdArg=0xA5A5; ack same cycle DMemReq is seen -> DMemWE=1, DMemWData=0xA5A5, stage takes 2 cycles, OWBData=0x0010.
- Reset asserted while in REQ, then ack arrives the cycle after reset -> next edge DMemReq=0 with all outputs 0; the late ack produces no OValid.
- IMemRead=IMemWrite=1 -> store issued (DMemWE=1); OWBData=IALUResult on completion.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4, ack never asserted -> after 4 REQ cycles, Stall drops, OMemErr pulses once, OValid=1, ORegWrite=0, state returns to IDLE.
